// File: rtl/amiga_clock_reset_gen.sv
// Master-clock divider for the colour-clock phases, CCK/CCKQ, E7M/CDAC and E,
// plus the power-on / keyboard system reset sequencer.
module amiga_clock_reset_gen #(
  parameter int PERIOD   = 8,
  parameter int PHASES   = 4,
  parameter int E_DIV    = 10,
  parameter int E_HIGH   = 4,
  parameter int RST_HOLD = 2863636,
  parameter int KBD_LOW  = 14318180
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SYNC,
  input  logic              KCLK,
  output logic [PHASES-1:0] PH,
  output logic              CCK,
  output logic              CCKQ,
  output logic              E7M,
  output logic              CDAC,
  output logic              E,
  output logic              E_LAST,
  output logic              _RST_OUT
);

  localparam int STEP = PERIOD / (2 * PHASES);
  localparam int CW   = $clog2(PERIOD);
  localparam int EW   = (E_DIV > 1)    ? $clog2(E_DIV)    : 1;
  localparam int HW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int KW   = (KBD_LOW > 1)  ? $clog2(KBD_LOW)  : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(PERIOD / 2);
  localparam logic [EW-1:0] ECNT_END = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_RISE   = EW'(E_DIV - E_HIGH);
  localparam logic [HW-1:0] HOLD_END = HW'(RST_HOLD - 1);
  localparam logic [KW-1:0] KBD_END  = KW'(KBD_LOW - 1);

  typedef enum logic [1:0] {HOLD, RUN, KWAIT, KRST} rst_state_e;

  logic [CW-1:0]     cnt;
  logic [EW-1:0]     ecnt;
  logic [HW-1:0]     hcnt;
  logic [KW-1:0]     kcnt;
  logic              kclk_meta;
  logic              kclk_sync;
  logic              e_step;
  logic [PHASES-1:0] ph_next;
  rst_state_e        state;

  // E7M rises in the output stage one CLK after cnt sits at 0 or PERIOD/2.
  assign e_step = (cnt == '0) || (cnt == CNT_HALF);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      ecnt <= '0;
    end else if (SYNC) begin
      cnt  <= '0;
      ecnt <= '0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (e_step) ecnt <= (ecnt == ECNT_END) ? '0 : ecnt + 1'b1;
    end
  end

  // NOTE: the combinational decode assigns a default before the loop so no
  // path through the block can leave ph_next holding state (no latch).
  always_comb begin
    ph_next = '0;
    for (int k = 0; k < PHASES; k++) begin
      ph_next[k] = ((int'(cnt) - k * STEP + PERIOD) % PERIOD) < (PERIOD / 2);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PH     <= '0;
      CCK    <= 1'b0;
      CCKQ   <= 1'b0;
      E7M    <= 1'b0;
      CDAC   <= 1'b1;
      E      <= 1'b0;
      E_LAST <= 1'b0;
    end else begin
      PH     <= ph_next;
      CCK    <= ph_next[0];
      CCKQ   <= ph_next[PHASES/2];
      E7M    <= ph_next[0] ^ ph_next[PHASES/2];
      CDAC   <= ~(ph_next[0] ^ ph_next[PHASES/2]);
      E      <= (ecnt >= E_RISE);
      E_LAST <= (ecnt == ECNT_END) && e_step;
    end
  end

  // KCLK comes straight off the keyboard connector; idle level is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kclk_meta <= 1'b1;
      kclk_sync <= 1'b1;
    end else begin
      kclk_meta <= KCLK;
      kclk_sync <= kclk_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= HOLD;
      hcnt     <= '0;
      kcnt     <= '0;
      _RST_OUT <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hcnt == HOLD_END) begin
            state    <= RUN;
            hcnt     <= '0;
            _RST_OUT <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        RUN: begin
          if (!kclk_sync) begin
            state <= KWAIT;
            kcnt  <= KW'(1);
          end
        end
        KWAIT: begin
          if (kclk_sync) begin
            state <= RUN;
            kcnt  <= '0;
          end else if (kcnt == KBD_END) begin
            state    <= KRST;
            kcnt     <= '0;
            _RST_OUT <= 1'b0;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
        KRST: begin
          // The keyboard must let go before the power-on style hold restarts.
          if (kclk_sync) begin
            state <= HOLD;
            hcnt  <= '0;
          end
        end
        default: begin
          state    <= HOLD;
          hcnt     <= '0;
          _RST_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amiga_clock_reset_gen.sv
// Randomised bench for amiga_clock_reset_gen against a time-since-origin
// reference model of the clock outputs and the reset sequencer.
module tb_amiga_clock_reset_gen;

  localparam int P    = 8;
  localparam int NPH  = 4;
  localparam int EDIV = 10;
  localparam int EHI  = 4;
  localparam int HOLD = 16;
  localparam int KBD  = 32;
  localparam int STEP = P / (2 * NPH);
  localparam int OW   = NPH + 7;
  localparam int TRACE_LEN = 48;

  // {PH, CCK, CCKQ, E7M, CDAC, E, E_LAST, _RST_OUT}: only CDAC is high in reset.
  localparam logic [OW-1:0] RST_VEC = OW'(8);

  logic           clk = 1'b0;
  logic           rst;
  logic           sync;
  logic           kclk;
  logic [NPH-1:0] ph;
  logic           cck, cckq, e7m, cdac, e, e_last, rst_out;
  logic [OW-1:0]  obs;

  amiga_clock_reset_gen #(
    .PERIOD(P), .PHASES(NPH), .E_DIV(EDIV), .E_HIGH(EHI),
    .RST_HOLD(HOLD), .KBD_LOW(KBD)
  ) dut (
    .CLK(clk), .RST(rst), .SYNC(sync), .KCLK(kclk),
    .PH(ph), .CCK(cck), .CCKQ(cckq), .E7M(e7m), .CDAC(cdac),
    .E(e), .E_LAST(e_last), ._RST_OUT(rst_out)
  );

  assign obs = {ph, cck, cckq, e7m, cdac, e, e_last, rst_out};

  initial forever #5 clk = ~clk;

  typedef enum {M_HOLD, M_UP, M_KBD} mmode_e;

  int            n;          // CLK edges since the last RST release or SYNC
  mmode_e        mmode;
  int            hold_edges;
  int            streak;     // consecutive edges the synced KCLK was seen low
  logic          kh1, kh2;   // KCLK as sampled one and two edges ago
  logic          exp_ro;
  logic [OW-1:0] exp_vec;
  logic [OW-1:0] trace0 [TRACE_LEN];
  int            tests = 0;
  int            fails = 0;

  task automatic model_reset();
    n          = 0;
    mmode      = M_HOLD;
    hold_edges = 0;
    streak     = 0;
    kh1        = 1'b1;
    kh2        = 1'b1;
    exp_ro     = 1'b0;
    exp_vec    = RST_VEC;
  endtask

  task automatic model_edge(input logic s, input logic k);
    int c, steps, ec;
    logic [NPH-1:0] eph;
    logic ks, x7;
    c     = n % P;
    steps = (n + P/2 - 1) / (P/2);   // E7M steps taken since the origin
    ec    = steps % EDIV;
    for (int j = 0; j < NPH; j++) eph[j] = ((c - j*STEP + P) % P) < P/2;
    x7 = eph[0] ^ eph[NPH/2];
    ks  = kh2;
    kh2 = kh1;
    kh1 = k;
    case (mmode)
      M_HOLD: begin
        hold_edges++;
        if (hold_edges == HOLD) begin mmode = M_UP; exp_ro = 1'b1; end
      end
      M_UP: begin
        if (!ks) begin
          streak++;
          if (streak == KBD) begin mmode = M_KBD; exp_ro = 1'b0; streak = 0; end
        end else begin
          streak = 0;
        end
      end
      M_KBD: if (ks) begin mmode = M_HOLD; hold_edges = 0; end
      default: ;
    endcase
    exp_vec = {eph, eph[0], eph[NPH/2], x7, ~x7, ec >= EDIV-EHI,
               (ec == EDIV-1) && (c % (P/2) == 0), exp_ro};
    n = s ? 0 : n + 1;
  endtask

  task automatic tick(input logic s, input logic k);
    sync = s;
    kclk = k;
    @(posedge clk);
    model_edge(s, k);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs !== RST_VEC) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", obs, RST_VEC);
    end
    release_rst();
  endtask

  task automatic test_clocks();
    for (int i = 0; i < TRACE_LEN; i++) begin
      tick(1'b0, 1'b1);
      trace0[i] = obs;
      tests++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL clocks cycle %0d: got %b expected %b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_hold_restart();
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== RST_VEC) begin
      fails++;
      $display("FAIL hold_async_rst: got %b expected %b", obs, RST_VEC);
    end
    model_reset();
    release_rst();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    release_rst();
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 1'b1);
      tests++;
      if (obs !== exp_vec || obs !== trace0[i]) begin
        fails++;
        $display("FAIL hold_restart cycle %0d: got %b expected %b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_sync();
    bit found = 0;
    for (int i = 0; i < 2*P && !found; i++) begin
      if (n % P == 5) found = 1;
      else tick(1'b0, 1'b1);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL sync_align: got cnt %0d required 5", n % P);
    end
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tests++;
    if (ph[0] !== 1'b1 || ph[NPH-1] !== 1'b0) begin
      fails++;
      $display("FAIL sync_restart: got PH %b required PH[0]=1 PH[3]=0", ph);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b1);
      tests++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL sync_after cycle %0d: got %b expected %b", i, obs, exp_vec);
      end
    end
    for (int r = 0; r < 8; r++) begin
      int gap  = $urandom_range(1, 20);
      int held = $urandom_range(1, 3);
      for (int i = 0; i < gap + held; i++) begin
        tick(i >= gap, 1'b1);
        tests++;
        if (obs !== exp_vec) begin
          fails++;
          $display("FAIL sync_rand %0d/%0d: got %b expected %b", r, i, obs, exp_vec);
        end
      end
    end
  endtask

  task automatic test_kbd();
    int lows [6];
    lows[0] = 20;
    lows[1] = 60;
    for (int r = 2; r < 6; r++) lows[r] = $urandom_range(2, 70);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < lows[r] + 40; i++) begin
        tick($urandom_range(0, 15) == 0, i >= lows[r]);
        tests++;
        if (obs !== exp_vec) begin
          fails++;
          $display("FAIL kbd low=%0d cycle %0d: got %b expected %b", lows[r], i, obs, exp_vec);
        end
      end
    end
  endtask

  task automatic check_replay(input string tag);
    for (int i = 0; i < TRACE_LEN; i++) begin
      tick(1'b0, 1'b1);
      tests++;
      if (obs !== exp_vec || obs !== trace0[i]) begin
        fails++;
        $display("FAIL %s replay cycle %0d: got %b expected %b", tag, i, obs, trace0[i]);
      end
    end
  endtask

  task automatic test_async_rst();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (exp_vec[2] && exp_ro) found = 1;
    end
    for (int i = 0; i < 2 && found; i++) tick(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    tests++;
    if (!found || obs !== RST_VEC) begin
      fails++;
      $display("FAIL rst_mid_e: got %b expected %b (E high seen %0d)", obs, RST_VEC, found);
    end
    model_reset();
    release_rst();
    check_replay("rst_mid_e");

    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick(1'b0, 1'b0);
      if (mmode == M_KBD) found = 1;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if (!found || obs !== RST_VEC) begin
      fails++;
      $display("FAIL rst_mid_krst: got %b expected %b (KRST seen %0d)", obs, RST_VEC, found);
    end
    model_reset();
    kclk = 1'b1;
    release_rst();
    check_replay("rst_mid_krst");
  endtask

  initial begin
    rst  = 1'b1;
    sync = 1'b0;
    kclk = 1'b1;
    model_reset();
    test_reset();
    test_clocks();
    test_hold_restart();
    test_sync();
    test_kbd();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
